// File: rtl/ahb_slave_pipe_if.sv
// ahb_slave_pipe_if: AHB slave-side bus bundle for the address/data pipeline and burst tracker
interface ahb_slave_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [1:0]        HTRANS;
    logic [1:0]        HBURST;
    logic              HREADY;
    logic [ADDR_W-1:0] HADDR;
    logic [DATA_W-1:0] HWDATA;
    logic              HWRITE;
    logic              valid;
    logic [ADDR_W-1:0] haddr1;
    logic [ADDR_W-1:0] haddr2;
    logic [DATA_W-1:0] hwdata1;
    logic [DATA_W-1:0] hwdata2;
    logic              hwrite_reg;
    logic              hwrite_reg1;
    logic [2:0]        tempselx;
    logic              burst_last;
    logic              burst_err;

    modport slave (
        input  HSEL, HTRANS, HBURST, HREADY, HADDR, HWDATA, HWRITE,
        output valid, haddr1, haddr2, hwdata1, hwdata2, hwrite_reg, hwrite_reg1,
               tempselx, burst_last, burst_err
    );

    modport master (
        output HSEL, HTRANS, HBURST, HREADY, HADDR, HWDATA, HWRITE,
        input  valid, haddr1, haddr2, hwdata1, hwdata2, hwrite_reg, hwrite_reg1,
               tempselx, burst_last, burst_err
    );
endinterface

// File: rtl/ahb_slave_pipe.sv
// ahb_slave_pipe: AHB slave address/data pipeline with peripheral decode; burst tracker enabled by AHB_SLAVE_PIPE_BURST_CHECK_EN
module ahb_slave_pipe #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic             Hclk,
    input logic             Hresetn,
    ahb_slave_pipe_if.slave bus
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(32'h8000_0000);
    localparam logic [ADDR_W-1:0] SEL1 = ADDR_W'(32'h8400_0000);
    localparam logic [ADDR_W-1:0] SEL2 = ADDR_W'(32'h8800_0000);
    localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(32'h8BFF_FFFF);

    logic in_range;

    assign in_range     = bus.HADDR >= BASE && bus.HADDR <= TOP;
    assign bus.valid    = bus.HSEL & bus.HREADY & bus.HTRANS[1] & in_range;
    assign bus.tempselx = !in_range ? 3'b000 : bus.HADDR < SEL1 ? 3'b001 : bus.HADDR < SEL2 ? 3'b010 : 3'b100;

    // two-stage address/data/direction pipeline, frozen while HREADY is low
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            bus.haddr1      <= '0;
            bus.haddr2      <= '0;
            bus.hwdata1     <= '0;
            bus.hwdata2     <= '0;
            bus.hwrite_reg  <= 1'b0;
            bus.hwrite_reg1 <= 1'b0;
        end else if (bus.HREADY) begin
            bus.haddr1      <= bus.HADDR;
            bus.haddr2      <= bus.haddr1;
            bus.hwdata1     <= bus.HWDATA;
            bus.hwdata2     <= bus.hwdata1;
            bus.hwrite_reg  <= bus.HWRITE;
            bus.hwrite_reg1 <= bus.hwrite_reg;
        end
    end

`ifdef AHB_SLAVE_PIPE_BURST_CHECK_EN
    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_INCR  = 2'd1;
    localparam logic [1:0] B_FIXED = 2'd2;

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] exp;
    logic [ADDR_W-1:0] nxt;

    // WRAP4 wraps inside the 16-byte block; every other burst steps linearly
    assign nxt = bus.HBURST == 2'b10 ? {bus.HADDR[ADDR_W-1:4], bus.HADDR[3:0] + 4'd4} : bus.HADDR + ADDR_W'(4);

    // burst tracker: NONSEQ opens a burst, SEQ beats are checked against the expected address
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state          <= B_IDLE;
            cnt            <= 2'd0;
            exp            <= '0;
            bus.burst_last <= 1'b0;
            bus.burst_err  <= 1'b0;
        end else begin
            bus.burst_last <= 1'b0;
            bus.burst_err  <= 1'b0;
            if (bus.valid && !bus.HTRANS[0]) begin
                bus.burst_err <= state == B_FIXED;
                if (bus.HBURST == 2'b00) begin
                    state <= B_IDLE;
                end else if (bus.HBURST == 2'b01) begin
                    state <= B_INCR;
                    exp   <= nxt;
                end else begin
                    state <= B_FIXED;
                    cnt   <= 2'd1;
                    exp   <= nxt;
                end
            end else if (bus.valid) begin
                if (state == B_IDLE) begin
                    bus.burst_err <= 1'b1;
                end else begin
                    bus.burst_err <= bus.HADDR != exp;
                    exp           <= nxt;
                    if (state == B_FIXED) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            bus.burst_last <= 1'b1;
                            state          <= B_IDLE;
                        end
                    end
                end
            end else if (bus.HREADY && bus.HTRANS == 2'b00 && state == B_FIXED && cnt < 2'd3) begin
                bus.burst_err <= 1'b1;
                state         <= B_IDLE;
            end
        end
    end
`else
    logic unused_burst;

    assign unused_burst   = ^bus.HBURST;
    assign bus.burst_last = 1'b0;
    assign bus.burst_err  = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_slave_pipe.sv
// tb_ahb_slave_pipe: directed scoreboard bench for ahb_slave_pipe
module tb_ahb_slave_pipe;
`ifdef AHB_SLAVE_PIPE_BURST_CHECK_EN
    localparam bit TRK = 1'b1;
`else
    localparam bit TRK = 1'b0;
`endif
    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [1:0] SGL = 2'b00, INC = 2'b01, WR4 = 2'b10, IN4 = 2'b11;

    typedef struct packed {
        logic [31:0] a1, a2, d1, d2;
        logic        w1, w2, last, err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic m_w1, m_w2;

    ahb_slave_pipe_if bus ();

    ahb_slave_pipe dut (
        .Hclk   (clk),
        .Hresetn(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] selx(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
        if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
        if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] t, input logic [1:0] b, input logic r,
                         input logic [31:0] a, input logic [31:0] d, input logic w);
        bus.HSEL = s; bus.HTRANS = t; bus.HBURST = b; bus.HREADY = r;
        bus.HADDR = a; bus.HWDATA = d; bus.HWRITE = w;
    endtask

    task automatic model_clear();
        m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w1 = 1'b0; m_w2 = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".haddr1"}, 64'(bus.haddr1), 64'd0);
        chk({tag, ".haddr2"}, 64'(bus.haddr2), 64'd0);
        chk({tag, ".hwdata1"}, 64'(bus.hwdata1), 64'd0);
        chk({tag, ".hwdata2"}, 64'(bus.hwdata2), 64'd0);
        chk({tag, ".hwrite"}, 64'({bus.hwrite_reg, bus.hwrite_reg1}), 64'd0);
        chk({tag, ".pulses"}, 64'({bus.burst_last, bus.burst_err}), 64'd0);
        chk({tag, ".valid"}, 64'(bus.valid), 64'd0);
        chk({tag, ".tempselx"}, 64'(bus.tempselx), 64'd0);
    endtask

    task automatic step(input string tag, input logic s, input logic [1:0] t, input logic [1:0] b,
                        input logic r, input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic el, input logic ee);
        exp_t e;
        @(negedge clk);
        drive(s, t, b, r, a, d, w);
        #1;
        chk({tag, ".valid"}, 64'(bus.valid), 64'(s & r & t[1] & (selx(a) != 3'b000)));
        chk({tag, ".tempselx"}, 64'(bus.tempselx), 64'(selx(a)));
        if (r) begin
            m_a2 = m_a1; m_a1 = a; m_d2 = m_d1; m_d1 = d; m_w2 = m_w1; m_w1 = w;
        end
        e = '{m_a1, m_a2, m_d1, m_d2, m_w1, m_w2, el & TRK, ee & TRK};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".haddr1"}, 64'(bus.haddr1), 64'(e.a1));
        chk({tag, ".haddr2"}, 64'(bus.haddr2), 64'(e.a2));
        chk({tag, ".hwdata1"}, 64'(bus.hwdata1), 64'(e.d1));
        chk({tag, ".hwdata2"}, 64'(bus.hwdata2), 64'(e.d2));
        chk({tag, ".hwrite_reg"}, 64'(bus.hwrite_reg), 64'(e.w1));
        chk({tag, ".hwrite_reg1"}, 64'(bus.hwrite_reg1), 64'(e.w2));
        chk({tag, ".burst_last"}, 64'(bus.burst_last), 64'(e.last));
        chk({tag, ".burst_err"}, 64'(bus.burst_err), 64'(e.err));
    endtask

    initial begin
        drive(1'b0, IDLE, SGL, 1'b0, 32'h0, 32'h0, 1'b0);
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("wr_single", 1, NSEQ, SGL, 1, 32'h8000_0010, 32'hA5A5_0001, 1, 0, 0);
        step("wr_next", 0, IDLE, SGL, 1, 32'h0, 32'h1111_2222, 0, 0, 0);
        step("wr_drain", 0, IDLE, SGL, 1, 32'h0, 32'h0, 0, 0, 0);
        step("out_range", 1, NSEQ, SGL, 1, 32'h8C00_0000, 32'h0BAD_0000, 1, 0, 0);
        step("low_edge", 1, NSEQ, SGL, 1, 32'h7FFF_FFFC, 32'h0, 0, 0, 0);
        step("top_edge", 1, NSEQ, SGL, 1, 32'h8BFF_FFFC, 32'h3, 1, 0, 0);
        step("s_a", 1, NSEQ, SGL, 1, 32'h8000_0100, 32'hD000_0001, 1, 0, 0);
        step("s_b", 1, NSEQ, SGL, 1, 32'h8400_0104, 32'hD000_0002, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 1, NSEQ, SGL, 0, 32'h8800_0200 + 32'(i), 32'hEEEE_0000 + 32'(i), 1, 0, 0);
        step("resume1", 1, NSEQ, SGL, 1, 32'h8000_0300, 32'hD000_0003, 1, 0, 0);
        step("resume2", 0, IDLE, SGL, 1, 32'h0, 32'hD000_0004, 0, 0, 0);
        step("wrap_b1", 1, NSEQ, WR4, 1, 32'h8400_0008, 32'h1, 1, 0, 0);
        step("wrap_b2", 1, SEQ, WR4, 1, 32'h8400_000C, 32'h2, 1, 0, 0);
        step("wrap_b3", 1, SEQ, WR4, 1, 32'h8400_0000, 32'h3, 1, 0, 0);
        step("wrap_b4", 1, SEQ, WR4, 1, 32'h8400_0004, 32'h4, 1, 1, 0);
        step("wrap_after", 0, IDLE, SGL, 1, 32'h0, 32'h0, 0, 0, 0);
        step("inc4_b1", 1, NSEQ, IN4, 1, 32'h8800_0000, 32'h10, 0, 0, 0);
        step("inc4_b2", 1, SEQ, IN4, 1, 32'h8800_0004, 32'h11, 0, 0, 0);
        step("inc4_b3bad", 1, SEQ, IN4, 1, 32'h8800_000C, 32'h12, 0, 0, 1);
        step("inc4_b4", 1, SEQ, IN4, 1, 32'h8800_0010, 32'h13, 0, 1, 0);
        step("inc4n_b1", 1, NSEQ, IN4, 1, 32'h8800_0020, 32'h20, 1, 0, 0);
        step("inc4n_b2", 1, SEQ, IN4, 1, 32'h8800_0024, 32'h21, 1, 0, 0);
        step("early_nseq", 1, NSEQ, IN4, 1, 32'h8800_0040, 32'h22, 1, 0, 1);
        step("early_idle", 1, IDLE, IN4, 1, 32'h8800_0044, 32'h23, 1, 0, 1);
        step("seq_in_idle", 1, SEQ, INC, 1, 32'h8000_0000, 32'h30, 0, 0, 1);
        step("incr_b1", 1, NSEQ, INC, 1, 32'h8000_0100, 32'h31, 0, 0, 0);
        step("incr_b2", 1, SEQ, INC, 1, 32'h8000_0104, 32'h32, 0, 0, 0);
        step("incr_b3bad", 1, SEQ, INC, 1, 32'h8000_010C, 32'h33, 0, 0, 1);
        step("incr_b4", 1, SEQ, INC, 1, 32'h8000_0110, 32'h34, 0, 0, 0);
        step("incr_end", 1, NSEQ, SGL, 1, 32'h8000_0200, 32'h35, 1, 0, 0);
        step("rst_b1", 1, NSEQ, IN4, 1, 32'h8800_0000, 32'h40, 1, 0, 0);
        step("rst_b2", 1, SEQ, IN4, 1, 32'h8800_0004, 32'h41, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, IDLE, SGL, 1'b1, 32'h0, 32'h0, 1'b0);
        #1;
        chk_all_zero("midrst");
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, IDLE, SGL, 1, 32'h0, 32'h0, 0, 0, 0);
        step("post_rst2", 1, NSEQ, SGL, 1, 32'h8800_0008, 32'h50, 1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ahb_slave_pipe.md
AHB_SLAVE_PIPE -- requirements
Module: ahb_slave_pipe

Interface
REQ-001 Parameters SHALL be, one per line: ADDR_W, 32, address width.
REQ-002 DATA_W, 32, write data width.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning): Hclk, in, 1, sole clock, rising edge.
REQ-004 Hresetn, in, 1, reset; asynchronous, active-low.
REQ-005 HSEL, in, 1, bridge selected.
REQ-006 HTRANS, in, 2, 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 HBURST, in, 2, 00 SINGLE, 01 INCR, 10 WRAP4, 11 INCR4.
REQ-008 HREADY, in, 1, bus ready, driven by the downstream bridge FSM.
REQ-009 HADDR, in, ADDR_W, address phase address.
REQ-010 HWDATA, in, DATA_W, data phase write data.
REQ-011 HWRITE, in, 1, 1 = write.
REQ-012 valid, out, 1, combinational accepted-beat flag.
REQ-013 haddr1 and haddr2, out, ADDR_W each, address delayed by 1 and 2 stages.
REQ-014 hwdata1 and hwdata2, out, DATA_W each, write data delayed by 1 and 2 stages.
REQ-015 hwrite_reg and hwrite_reg1, out, 1 each, HWRITE delayed by 1 and 2 stages.
REQ-016 tempselx, out, 3, one-hot peripheral select.
REQ-017 burst_last, out, 1, one-cycle pulse on the final beat of a fixed burst.
REQ-018 burst_err, out, 1, one-cycle pulse on a protocol violation.

Function
REQ-019 valid SHALL equal HSEL & HREADY & HTRANS[1] & (0x8000_0000 <= HADDR <= 0x8BFF_FFFF), combinationally, in the same cycle.
REQ-020 tempselx SHALL be combinational from HADDR: 0x8000_0000-0x83FF_FFFF gives 001, 0x8400_0000-0x87FF_FFFF gives 010, 0x8800_0000-0x8BFF_FFFF gives 100, any other address gives 000.
REQ-021 When HREADY=1, the pipeline SHALL update every edge: haddr1<=HADDR, haddr2<=haddr1, hwdata1<=HWDATA, hwdata2<=hwdata1, hwrite_reg<=HWRITE, hwrite_reg1<=hwrite_reg.
REQ-022 When HREADY=0, all pipeline registers SHALL hold their values.
REQ-023 Pipeline latency SHALL be 1 cycle for stage 1 and 2 cycles for stage 2.
REQ-024 The burst tracker FSM SHALL have three states: B_IDLE, B_INCR and B_FIXED, plus a 2-bit beat counter cnt and an expected-address register exp.
REQ-025 The tracker SHALL act only on cycles where valid=1.
REQ-026 On BUSY, or when valid=0, the tracker SHALL hold its state; exception: an IDLE HTRANS in B_FIXED with cnt<3 SHALL pulse burst_err and go to B_IDLE.
REQ-027 On a NONSEQ beat:
- SINGLE: go to B_IDLE.
- INCR: go to B_INCR, exp=HADDR+4.
- INCR4 or WRAP4: go to B_FIXED, cnt=1, exp=next(HADDR).
REQ-028 A NONSEQ beat arriving in B_FIXED with cnt<=3 SHALL pulse burst_err, then be processed per REQ-027.
REQ-029 next(a) SHALL be a+4 for INCR4, and {a[ADDR_W-1:4], (a[3:0]+4) mod 16} for WRAP4; a carry out of bit 31 is discarded.
REQ-030 A SEQ beat in B_IDLE SHALL pulse burst_err; the state stays B_IDLE.
REQ-031 A SEQ beat in B_INCR or B_FIXED with HADDR!=exp SHALL pulse burst_err; tracking then continues from HADDR.
REQ-032 Each SEQ beat in B_INCR or B_FIXED SHALL set exp=next(HADDR).
REQ-033 In B_FIXED, each SEQ beat SHALL increment cnt.
REQ-034 On the SEQ beat with cnt=3 (the 4th beat), the tracker SHALL pulse burst_last and go to B_IDLE.
REQ-035 burst_err and burst_last SHALL be registered, asserting the cycle after the triggering beat; they are never asserted together unless both conditions hold.

Reset
REQ-036 Hresetn low SHALL asynchronously clear haddr1, haddr2, hwdata1, hwdata2, hwrite_reg, hwrite_reg1, burst_last, burst_err, cnt and exp to 0, and set state to B_IDLE.
REQ-037 A reset asserted mid-burst SHALL discard the burst without a burst_err pulse.
REQ-038 Deassertion SHALL take effect at the first rising edge of Hclk after Hresetn goes high.

Configuration
REQ-039 Macro AHB_SLAVE_PIPE_BURST_CHECK_EN SHALL control the tracker.
- Defined: the tracker of REQ-024 to REQ-035 is compiled in.
- Undefined: the tracker is absent, burst_last and burst_err are tied to 0, ports are unchanged and all other behaviour is identical.

Verification
REQ-040 Single write: HSEL=1, HREADY=1, NONSEQ, HADDR=0x8000_0010, HWRITE=1, HWDATA=0xA5A5_0001 -> valid=1, tempselx=001 in that cycle; haddr1=0x8000_0010 at +1; haddr2 and hwdata2 valid at +2.
REQ-041 Out-of-range address: HADDR=0x8C00_0000 with NONSEQ and HSEL=1 -> valid=0, tempselx=000, no tracker activity.
REQ-042 Stall: HREADY=0 held 3 cycles mid-stream -> every pipeline output holds; it resumes shifting when HREADY returns to 1.
REQ-043 WRAP4 burst at 0x8400_0008: beats 08, 0C, 00, 04 -> burst_last pulses once, the cycle after beat 4; burst_err stays 0; tempselx=010.
REQ-044 INCR4 from 0x8800_0000 with the 3rd beat at 0x8800_000C -> burst_err pulses the cycle after beat 3; a NONSEQ after beat 2 of a new INCR4 also pulses burst_err.
REQ-045 Hresetn pulsed low after beat 2 of an INCR4 -> all outputs read 0 immediately; no burst_err; with the macro undefined, the REQ-043 stimulus gives burst_last=0.
